// File: rtl/orientation_histogram.sv
// Orientation histogram for one keypoint window: bins CORDIC magnitude/angle pairs
// into 36 ten-degree bins, then scans for the dominant bin and its peak weight.
module orientation_histogram #(
  parameter int BitSize = 16,
  parameter int AccW    = 24
) (
  input  logic                      iclk,
  input  logic                      ireset,
  input  logic                      ivalid,
  input  logic                      ilast,
  input  logic signed [BitSize:0]   imag,
  input  logic signed [BitSize:0]   iangle,
  output logic                      iready,
  output logic                      ovalid,
  output logic [5:0]                obin,
  output logic [AccW-1:0]           opeak
);

  localparam int NumBins = 36;
  localparam int BinSpan = 640;

  typedef enum logic [1:0] {ACCUM, DRAIN, SCAN, DONE} state_t;

  state_t              state, state_nxt;
  logic                accept;
  logic [5:0]          angle_bin;
  logic [BitSize-1:0]  mag_clamp;

  logic                s1_valid;
  logic [5:0]          s1_bin;
  logic [BitSize-1:0]  s1_mag;

  logic [AccW-1:0]     hist [NumBins];
  logic [AccW:0]       acc_sum;
  logic [AccW-1:0]     acc_sat;

  logic [5:0]          scan_idx;
  logic [5:0]          max_bin, max_bin_nxt;
  logic [AccW-1:0]     max_peak, max_peak_nxt;

  assign accept = ivalid & iready;

  // NOTE: every always_comb output gets a default first, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    state_nxt = state;
    iready    = 1'b0;
    ovalid    = 1'b0;
    case (state)
      ACCUM: begin
        iready = 1'b1;
        if (ivalid && ilast) state_nxt = DRAIN;
      end
      DRAIN: state_nxt = SCAN;
      SCAN:  if (scan_idx == 6'(NumBins - 1)) state_nxt = DONE;
      DONE: begin
        ovalid    = 1'b1;
        state_nxt = ACCUM;
      end
      default: state_nxt = ACCUM;
    endcase
  end

  // Comparator ladder: bin = number of 640-wide boundaries at or below the angle,
  // which equals floor(angle/640) and clamps both out-of-range sides for free.
  always_comb begin
    angle_bin = '0;
    for (int k = 1; k < NumBins; k++) begin
      if (int'(iangle) >= BinSpan * k) angle_bin = 6'(k);
    end
  end

  assign mag_clamp = imag[BitSize] ? '0 : imag[BitSize-1:0];

  assign acc_sum = {1'b0, hist[s1_bin]} + (AccW + 1)'(s1_mag);
  assign acc_sat = acc_sum[AccW] ? '1 : acc_sum[AccW-1:0];

  // Strictly greater keeps the lowest index on ties.
  always_comb begin
    max_bin_nxt  = max_bin;
    max_peak_nxt = max_peak;
    if (hist[scan_idx] > max_peak) begin
      max_bin_nxt  = scan_idx;
      max_peak_nxt = hist[scan_idx];
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge iclk or posedge ireset) begin
    if (ireset) begin
      state    <= ACCUM;
      s1_valid <= 1'b0;
      s1_bin   <= '0;
      s1_mag   <= '0;
    end else begin
      state    <= state_nxt;
      s1_valid <= accept;
      if (accept) begin
        s1_bin <= angle_bin;
        s1_mag <= mag_clamp;
      end
    end
  end

  // NOTE: the bins are reset explicitly because an aborted window must never leak into the next result.
  always_ff @(posedge iclk or posedge ireset) begin
    if (ireset) begin
      for (int i = 0; i < NumBins; i++) hist[i] <= '0;
    end else if (state == DONE) begin
      for (int i = 0; i < NumBins; i++) hist[i] <= '0;
    end else if (s1_valid) begin
      hist[s1_bin] <= acc_sat;
    end
  end

  // Results are captured on the final scan edge so they are stable throughout DONE.
  always_ff @(posedge iclk or posedge ireset) begin
    if (ireset) begin
      scan_idx <= '0;
      max_bin  <= '0;
      max_peak <= '0;
      obin     <= '0;
      opeak    <= '0;
    end else if (state == SCAN) begin
      max_bin  <= max_bin_nxt;
      max_peak <= max_peak_nxt;
      scan_idx <= scan_idx + 6'd1;
      if (scan_idx == 6'(NumBins - 1)) begin
        obin  <= max_bin_nxt;
        opeak <= max_peak_nxt;
      end
    end else if (state == DONE) begin
      scan_idx <= '0;
      max_bin  <= '0;
      max_peak <= '0;
    end
  end

endmodule

// File: tb/tb_orientation_histogram.sv
// Self-checking bench for orientation_histogram: table of single-sample windows plus
// hand-written multi-sample sequences, results checked through a scoreboard queue.
module tb_orientation_histogram;

  localparam int BitSize = 16;
  localparam int AccW    = 24;
  localparam int Latency = 37;

  logic                    iclk = 1'b0;
  logic                    ireset;
  logic                    ivalid;
  logic                    ilast;
  logic signed [BitSize:0] imag;
  logic signed [BitSize:0] iangle;
  logic                    iready;
  logic                    ovalid;
  logic [5:0]              obin;
  logic [AccW-1:0]         opeak;

  orientation_histogram #(.BitSize(BitSize), .AccW(AccW)) dut (
    .iclk   (iclk),
    .ireset (ireset),
    .ivalid (ivalid),
    .ilast  (ilast),
    .imag   (imag),
    .iangle (iangle),
    .iready (iready),
    .ovalid (ovalid),
    .obin   (obin),
    .opeak  (opeak)
  );

  always #5 iclk = ~iclk;

  typedef struct {
    int mag;
    int angle;
    int exp_bin;
    int exp_peak;
  } vec_t;

  typedef struct {
    int bin;
    int peak;
    int acc_edge;
  } exp_t;

  exp_t q[$];
  int   n_checks = 0;
  int   n_pass   = 0;
  int   cyc      = 0;
  int   last_acc = 0;

  always @(posedge iclk) cyc <= cyc + 1;

  task automatic check(input string name, input longint act, input longint exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
  endtask

  // Scoreboard consumer: every ovalid pulse must match the oldest pending window.
  always @(negedge iclk) begin
    if (ovalid) begin
      if (q.size() == 0) begin
        check("unexpected_ovalid", 1, 0);
      end else begin
        exp_t e;
        e = q.pop_front();
        check("obin", obin, e.bin);
        check("opeak", opeak, e.peak);
        check("ovalid_latency", cyc - e.acc_edge, Latency);
      end
    end
  end

  task automatic send(input int mag, input int angle, input bit last,
                      input int exp_bin, input int exp_peak);
    int guard;
    guard  = 0;
    imag   = 17'(mag);
    iangle = 17'(angle);
    ivalid = 1'b1;
    ilast  = last;
    while (!iready && guard < 100) begin
      @(posedge iclk); #1;
      guard++;
    end
    if (!iready) check("iready_timeout", 0, 1);
    @(posedge iclk); #1;
    last_acc = cyc;
    ivalid = 1'b0;
    ilast  = 1'b0;
    if (last) begin
      exp_t e;
      e.bin = exp_bin; e.peak = exp_peak; e.acc_edge = last_acc;
      q.push_back(e);
    end
  endtask

  task automatic wait_results();
    int guard;
    guard = 0;
    while (q.size() != 0 && guard < 200) begin
      @(posedge iclk); #1;
      guard++;
    end
    check("result_timeout", q.size(), 0);
    repeat (2) @(posedge iclk);
    #1;
  endtask

  vec_t vecs[$];

  initial begin
    int g;
    vecs = '{
      '{10,        0,  0,    10},
      '{11,      639,  0,    11},
      '{12,      640,  1,    12},
      '{13,     1279,  1,    13},
      '{14,     1280,  2,    14},
      '{15,    11519, 17,    15},
      '{16,    11520, 18,    16},
      '{17,    23039, 35,    17},
      '{18,    23040, 35,    18},
      '{33,       -5,  0,    33},
      '{12,    23500, 35,    12},
      '{65535, 65535, 35, 65535},
      '{9,    -65536,  0,     9}
    };

    ireset = 1'b1; ivalid = 1'b0; ilast = 1'b0; imag = '0; iangle = '0;
    repeat (3) @(posedge iclk);
    #1;
    check("rst_iready", iready, 1);
    check("rst_ovalid", ovalid, 0);
    check("rst_obin", obin, 0);
    check("rst_opeak", opeak, 0);
    ireset = 1'b0;
    @(posedge iclk); #1;
    check("post_rst_iready", iready, 1);

    foreach (vecs[i]) begin
      send(vecs[i].mag, vecs[i].angle, 1'b1, vecs[i].exp_bin, vecs[i].exp_peak);
      wait_results();
    end

    // Single dominant bin built from two samples.
    send(100, 5760, 1'b0, 0, 0);
    send(30,  640,  1'b0, 0, 0);
    send(50,  5799, 1'b1, 9, 150);
    wait_results();
    check("obin_hold", obin, 9);
    check("opeak_hold", opeak, 150);

    // Tie between bin 0 and bin 35 goes to the lower index.
    send(40, 639,   1'b0, 0, 0);
    send(40, 22400, 1'b1, 0, 40);
    wait_results();

    // Saturating accumulation, back-to-back into one bin.
    for (int i = 0; i < 299; i++) send(65535, 3 * 640 + 5, 1'b0, 0, 0);
    send(65535, 3 * 640, 1'b1, 3, (1 << AccW) - 1);
    wait_results();

    // Consecutive same-bin adds below saturation, mixed with a smaller bin.
    send(60, 100, 1'b0, 0, 0);
    for (int i = 0; i < 9; i++) send(7, 12 * 640, 1'b0, 0, 0);
    send(7, 12 * 640 + 639, 1'b1, 12, 70);
    wait_results();

    // Input held valid through DRAIN/SCAN/DONE must be dropped.
    send(10, 4 * 640, 1'b1, 4, 10);
    imag = 17'(1000); iangle = 17'(20 * 640); ivalid = 1'b1; ilast = 1'b0;
    g = 0;
    while (!iready && g < 100) begin
      @(posedge iclk); #1;
      g++;
    end
    check("next_accept_edge", cyc + 1 - last_acc, 39);
    imag = 17'(5); iangle = 17'(6 * 640); ilast = 1'b1;
    @(posedge iclk); #1;
    begin
      exp_t e;
      e.bin = 6; e.peak = 5; e.acc_edge = cyc;
      q.push_back(e);
    end
    ivalid = 1'b0; ilast = 1'b0;
    wait_results();

    // Empty window: negative magnitude counts as zero.
    send(-3, 7000, 1'b1, 0, 0);
    wait_results();
    check("no_extra_ovalid", ovalid, 0);

    // Make the outputs nonzero, then reset mid-window.
    send(77, 8 * 640, 1'b1, 8, 77);
    wait_results();
    send(500, 7 * 640, 1'b0, 0, 0);
    send(500, 7 * 640, 1'b0, 0, 0);
    ireset = 1'b1;
    #2;
    check("mid_rst_ovalid", ovalid, 0);
    check("mid_rst_obin", obin, 0);
    check("mid_rst_opeak", opeak, 0);
    @(negedge iclk);
    ireset = 1'b0;
    @(posedge iclk); #1;
    check("mid_rst_iready", iready, 1);
    send(20, 2 * 640, 1'b1, 2, 20);
    wait_results();

    // Reset mid-scan aborts the pending result.
    send(300, 11 * 640, 1'b1, 11, 300);
    repeat (10) @(posedge iclk);
    #1;
    ireset = 1'b1;
    q.delete();
    #2;
    check("scan_rst_iready", iready, 1);
    @(negedge iclk);
    ireset = 1'b0;
    send(25, 30 * 640, 1'b1, 30, 25);
    wait_results();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/orientation_histogram.md
# orientation_histogram

Accumulates CORDIC magnitude/angle pairs from one keypoint's gradient window into a 36-bin orientation histogram, then scans the histogram and reports the dominant orientation bin and its peak weight. It sits directly downstream of the CORDIC magnitude/angle stage and consumes its `ox` (magnitude) and `oz` (angle, degrees × 64, range 0..23039) outputs. It feeds keypoint orientation assignment in the SIFT pipeline.

## Interface
- `BitSize`, 16: input data width is `BitSize+1` bits, signed.
- `AccW`, 24: histogram bin accumulator width, unsigned.
- `iclk` in 1: clock.
- `ireset` in 1: asynchronous, active-high reset.
- `ivalid` in 1: sample valid.
- `ilast` in 1: marks the final sample of a window. Qualified by `ivalid & iready`.
- `imag` in BitSize+1: gradient magnitude, signed. Negative values are treated as 0.
- `iangle` in BitSize+1: angle in units of 1/64 degree.
- `iready` out 1: block accepts samples. A sample is accepted on a rising edge where `ivalid & iready`.
- `ovalid` out 1: one-cycle pulse; `obin` and `opeak` are valid.
- `obin` out 6: dominant bin index, 0..35.
- `opeak` out AccW: accumulated weight of the dominant bin.

## Operation
**Bin mapping**
- bin = floor(iangle / 640), so each bin covers 10°.
- iangle < 0 maps to bin 0.
- iangle ≥ 23040 maps to bin 35.
- The mapping is exact for 0..23039. The implementation may use a comparator tree or a reciprocal multiply; whichever is used must match floor division exactly.

**Pipeline**
- Stage 1: on acceptance, register the bin index and the clamped magnitude.
- Stage 2: on the next edge, add the stage-1 magnitude into `hist[bin]`.
- Bins are registers, so consecutive samples to the same bin accumulate correctly with no hazard.
- Addition saturates at 2^AccW−1.

**FSM states: ACCUM, DRAIN, SCAN, DONE**
- ACCUM: `iready` = 1. Accepting a sample with `ilast` = 1 moves to DRAIN.
- DRAIN (1 cycle): `iready` = 0. Stage 2 adds the last sample.
- SCAN (36 cycles): `iready` = 0.
  - An index counter runs 0..35, comparing `hist[idx]` against the running max.
  - The running max updates only on strictly greater, so the lowest index wins ties.
  - The running max is initialised to bin 0, weight 0.
- DONE (1 cycle):
  - `ovalid` = 1; `obin`/`opeak` are driven from registers.
  - All 36 bins, the running max and the index counter are cleared at the exit edge.
  - The FSM then returns to ACCUM.
- An empty or all-zero window reports obin = 0, opeak = 0.

**Handshake**
- While `iready` = 0, `ivalid` is ignored; samples are dropped, not buffered. Upstream holds or discards them.
- There is no output back-pressure.

**Reset (async, active-high; asserting mid-window or mid-scan aborts the window)**
- FSM returns to ACCUM.
- All bins and pipeline registers are cleared.
- Outputs: `iready` = 1 once released, `ovalid` = 0, `obin` = 0, `opeak` = 0.

## Timing
- Edge N accepts the `ilast` sample; `iready` is low from after edge N.
- Edge N+1: last sample is summed.
- Edges N+2..N+37: scan bins 0..35.
- `ovalid` is high between edges N+37 and N+38.
- `iready` returns high after edge N+38. The earliest next-window sample is accepted at edge N+39.
- Per-window overhead is 38 cycles. Throughput in ACCUM is one sample per cycle.
- `obin`/`opeak` hold their values after `ovalid` until the next DONE or reset.

## Test plan
- **Reset:** assert `ireset` mid-stream → `ovalid`/`obin`/`opeak` = 0 and `iready` = 1 after release. Next window result excludes pre-reset samples.
- **Single peak:** window (mag 100, angle 5760), (mag 30, angle 640), (mag 50, angle 5799, ilast) → `ovalid` 37 edges after the last acceptance, obin = 9, opeak = 150.
- **Tie and boundaries:**
  - Samples (mag 40, angle 639) and (mag 40, angle 22400) → obin = 0, opeak = 40. The tie goes to the lower index, and 22400 maps to bin 35.
  - Angles −5 and 23500 → bins 0 and 35.
- **Saturation:** with AccW = 24, 300 back-to-back samples of mag 65535 to bin 3 → opeak = 16777215, obin = 3. Consecutive same-bin adds must not be lost below saturation: 10 × mag 7 gives 70.
- **Handshake:** hold `ivalid` = 1 with mag 1000, bin 20 during DRAIN/SCAN/DONE → ignored, so the next window excludes them. The next window starts cleanly at edge N+39.
- **Empty window:** a single sample with mag −3 and ilast → obin = 0, opeak = 0, `ovalid` pulses exactly once.
